link_tx_engine: RTL and testbench
=================================

Name: link_tx_engine

Overview:
- Consumer end of the ready/go grant protocol.
- Watches the go strobes issued by the high-priority queue server and the N_L low-priority clients, as granted by round_robin_FP.
- Latches the winning packet length and occupies the output link for that many slot cycles, then inserts an inter-packet gap.
- Checks protocol integrity: go conflicts, go-while-busy, and grant/go mismatch. Counts transmitted packets.

Parameters:
- N_L, 2, number of low-priority sources (1..15).
- LEN_W, 8, width of the packet-length fields.
- IFG, 1, inter-packet gap in cycles (1..15).

Ports:
- clk  in  1  system clock; rising-edge logic only.
- rst  in  1  reset; asynchronous, active-high.
- bool_go_H  in  1  go strobe from the high-priority server.
- bool_go_L  in  N_L  go strobes from the low-priority clients.
- pkt_len_H  in  LEN_W  packet length from the H server; valid in the go cycle.
- pkt_len_L  in  N_L*LEN_W  packet lengths from the L clients; slice i is bits [i*LEN_W +: LEN_W].
- active  in  2  arbiter grant class: 00 none, 01 H, 10 L.
- channel  in  4  binary index of the granted L client; meaningful when active=10.
- tx_valid  out  1  link slot occupied this cycle.
- tx_src  out  4  source of the current packet: 0 = H, i+1 = L client i.
- tx_remain  out  LEN_W  slots remaining after the current slot.
- tx_last  out  1  final slot of the packet.
- pkt_done  out  1  one-cycle pulse on packet completion.
- pkt_cnt  out  16  completed packets; wraps.
- err_conflict  out  1  sticky: more than one go in the same cycle.
- err_overlap  out  1  sticky: go while not IDLE.
- err_grant  out  1  sticky: go source disagrees with active/channel.

Behaviour:
- Reset (asynchronous, immediate, also mid-packet): state IDLE. All outputs 0: tx_valid, tx_src, tx_remain, tx_last, pkt_done, pkt_cnt, and all err_* flags. Any latched packet is discarded and not counted.
- States: IDLE, SEND, GAP. A gap counter counts IFG cycles.
- IDLE, sampled at posedge k:
  - No go: stay in IDLE.
  - Exactly one go: latch src and len.
    - len>=1: go to SEND.
    - len=0: go directly to GAP with no tx_valid. The zero-length packet still counts as a packet.
  - Two or more go: set err_conflict, start nothing, stay in IDLE.
- Grant check, on the single-go case only: err_grant is set if either of these holds:
  - go_H and active!=01;
  - go_L[i] and (active!=10 or channel!=i).
  The packet is still transmitted.
- SEND:
  - tx_valid=1 for cycles k+1 .. k+len.
  - tx_remain=len-1 at k+1, decrementing by 1 each cycle.
  - tx_last=1 when tx_remain=0, i.e. at cycle k+len.
  - tx_src holds the latched source throughout.
  - After the tx_last cycle, go to GAP.
- GAP:
  - Lasts IFG cycles.
  - pkt_done=1 in the first GAP cycle only: k+len+1, or k+1 for len=0.
  - pkt_cnt increments in the same cycle pkt_done is asserted; 16'hFFFF wraps to 0.
  - tx_valid=0 and tx_remain=0 throughout.
  - Return to IDLE after IFG cycles. A new go is accepted at the first IDLE posedge.
- Any go in SEND or GAP: set err_overlap. The go is ignored and the current packet continues unaffected.
- tx_src keeps its last value in IDLE and GAP.
- Length arithmetic is unsigned LEN_W bits. len=2^LEN_W-1 gives 255 slots at default width.
- Err flags clear only on rst.

Test Plan:
1. rst pulse, then go_H with pkt_len_H=4 and active=01 -> tx_valid high for 4 cycles; tx_remain 3,2,1,0; tx_last on the 4th cycle; pkt_done next cycle; pkt_cnt=1; all err_* = 0.
2. go_L[1] with len=8, active=10, channel=1; after the gap, go_L[0] with len=3, channel=0 -> tx_src=2 for 8 slots, then tx_src=1 for 3 slots; pkt_cnt=2.
3. go_H and go_L[0] in the same cycle -> err_conflict=1; tx_valid stays 0; pkt_cnt unchanged.
4. go_L[0] with len=5; go_H one cycle later; go_L[0] with len=0 during GAP (IFG=3) -> err_overlap=1; exactly 5 slots sent. A later len=0 go in IDLE produces pkt_done with no tx_valid.
5. go_L[0] with active=01 -> err_grant=1; the packet is still sent in full.
6. Assert rst at the 3rd slot of an 8-slot packet -> all outputs 0 immediately; pkt_cnt=0; after release, a new go_H with len=2 transmits normally.

Source files
------------

// File: rtl/link_tx_engine_if.sv
// Grant/go bundle into the link transmit engine and its link-side status.
// master: drives go strobes, lengths and grant info; slave: the engine.
interface link_tx_engine_if #(
  parameter int N_L   = 2,
  parameter int LEN_W = 8
);
  logic                   bool_go_H;
  logic [N_L-1:0]         bool_go_L;
  logic [LEN_W-1:0]       pkt_len_H;
  logic [N_L*LEN_W-1:0]   pkt_len_L;
  logic [1:0]             active;
  logic [3:0]             channel;
  logic                   tx_valid;
  logic [3:0]             tx_src;
  logic [LEN_W-1:0]       tx_remain;
  logic                   tx_last;
  logic                   pkt_done;
  logic [15:0]            pkt_cnt;
  logic                   err_conflict;
  logic                   err_overlap;
  logic                   err_grant;

  modport master (
    output bool_go_H, bool_go_L, pkt_len_H, pkt_len_L,
    output active, channel,
    input  tx_valid, tx_src, tx_remain, tx_last,
    input  pkt_done, pkt_cnt,
    input  err_conflict, err_overlap, err_grant
  );

  modport slave (
    input  bool_go_H, bool_go_L, pkt_len_H, pkt_len_L,
    input  active, channel,
    output tx_valid, tx_src, tx_remain, tx_last,
    output pkt_done, pkt_cnt,
    output err_conflict, err_overlap, err_grant
  );
endinterface

// File: rtl/link_tx_engine.sv
// Link transmit engine: takes the single granted go, sends len slots, then
// an IFG gap; flags go conflicts/overlaps/grant mismatches, counts packets.
// Ports: clk, rst (async active-high), bus (link_tx_engine_if.slave).
module link_tx_engine #(
  parameter int N_L   = 2,
  parameter int LEN_W = 8,
  parameter int IFG   = 1
) (
  input  logic             clk,
  input  logic             rst,
  link_tx_engine_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [3:0] GAP_END = 4'(IFG - 1);

  state_t           state;
  state_t           state_n;
  logic [3:0]       src;
  logic [LEN_W-1:0] remain;
  logic [3:0]       gap_cnt;
  logic [15:0]      cnt;
  logic             e_conf;
  logic             e_ovl;
  logic             e_grant;

  logic             go_any;
  logic             go_multi;
  logic [3:0]       sel_src;
  logic [LEN_W-1:0] sel_len;
  logic             sel_bad;
  logic             start;

  // Source decode; only meaningful when exactly one go is present.
  always_comb begin
    go_any   = bus.bool_go_H | (|bus.bool_go_L);
    go_multi = $countones({bus.bool_go_L, bus.bool_go_H}) > 1;
    sel_src  = '0;
    sel_len  = bus.pkt_len_H;
    sel_bad  = bus.active != 2'b01;
    for (int i = 0; i < N_L; i++) begin
      if (bus.bool_go_L[i]) begin
        sel_src = 4'(i + 1);
        sel_len = bus.pkt_len_L[i*LEN_W +: LEN_W];
        sel_bad = (bus.active != 2'b10) || (bus.channel != 4'(i));
      end
    end
    start = (state == IDLE) && go_any && !go_multi;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      src     <= '0;
      remain  <= '0;
      gap_cnt <= '0;
      cnt     <= '0;
      e_conf  <= 1'b0;
      e_ovl   <= 1'b0;
      e_grant <= 1'b0;
    end else begin
      state   <= state_n;
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      if (start) begin
        src    <= sel_src;
        remain <= (sel_len == '0) ? '0 : sel_len - LEN_W'(1);
      end else if (state == SEND && remain != '0) begin
        remain <= remain - LEN_W'(1);
      end
      // Count on GAP entry so pkt_cnt moves together with pkt_done.
      if (state_n == GAP && state != GAP)
        cnt <= cnt + 16'd1;
      if (state == IDLE && go_multi)
        e_conf <= 1'b1;
      if (state != IDLE && go_any)
        e_ovl <= 1'b1;
      if (start && sel_bad)
        e_grant <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (start) state_n = (sel_len == '0) ? GAP : SEND;
      SEND: if (remain == '0) state_n = GAP;
      GAP:  if (gap_cnt == GAP_END) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bus.tx_valid     = state == SEND;
    bus.tx_remain    = (state == SEND) ? remain : '0;
    bus.tx_last      = (state == SEND) && (remain == '0);
    bus.pkt_done     = (state == GAP) && (gap_cnt == 4'd0);
    bus.tx_src       = src;
    bus.pkt_cnt      = cnt;
    bus.err_conflict = e_conf;
    bus.err_overlap  = e_ovl;
    bus.err_grant    = e_grant;
  end

endmodule

// File: tb/tb_link_tx_engine.sv
// Directed bench for link_tx_engine (N_L=2, LEN_W=8, IFG=3).
// Inputs driven on negedge, outputs sampled on negedge.
module tb_link_tx_engine;
  localparam int N_L = 2;
  localparam int LW  = 8;
  localparam int IFG = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] exp_cnt = '0;

  link_tx_engine_if #(.N_L(N_L), .LEN_W(LW)) bus ();

  link_tx_engine #(.N_L(N_L), .LEN_W(LW), .IFG(IFG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic clear_in;
    bus.bool_go_H = 1'b0;
    bus.bool_go_L = '0;
    bus.pkt_len_H = '0;
    bus.pkt_len_L = '0;
    bus.active    = 2'b00;
    bus.channel   = 4'd0;
  endtask

  // One-cycle go pulse; returns at the negedge after the sampling edge.
  task automatic go(input logic h, input logic [1:0] l,
                    input logic [7:0] lh, input logic [15:0] ll,
                    input logic [1:0] act, input logic [3:0] ch);
    @(negedge clk);
    bus.bool_go_H = h;
    bus.bool_go_L = l;
    bus.pkt_len_H = lh;
    bus.pkt_len_L = ll;
    bus.active    = act;
    bus.channel   = ch;
    @(negedge clk);
    bus.bool_go_H = 1'b0;
    bus.bool_go_L = '0;
  endtask

  task automatic wait_idle;
    repeat (IFG + 1) @(negedge clk);
  endtask

  task automatic test_reset;
    clear_in();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.tx_valid, bus.tx_src, bus.tx_remain, bus.tx_last, bus.pkt_done,
         bus.pkt_cnt, bus.err_conflict, bus.err_overlap, bus.err_grant} !== '0) begin
      n_bad++;
      $display("FAIL reset_outs: got v=%b src=%0d rem=%0d cnt=%0d expected all 0",
               bus.tx_valid, bus.tx_src, bus.tx_remain, bus.pkt_cnt);
    end
    rst = 1'b0;
    exp_cnt = '0;
  endtask

  task automatic test_single_h;
    go(1'b1, 2'b00, 8'd4, 16'd0, 2'b01, 4'd0);
    for (int s = 0; s < 4; s++) begin
      n_cmp++;
      if ({bus.tx_valid, bus.tx_remain, bus.tx_last, bus.tx_src} !==
          {1'b1, 8'(3 - s), (s == 3), 4'd0}) begin
        n_bad++;
        $display("FAIL h_slot%0d: got v=%b rem=%0d last=%b src=%0d expected 1/%0d/%0d/0",
                 s, bus.tx_valid, bus.tx_remain, bus.tx_last, bus.tx_src, 3 - s, s == 3);
      end
      @(negedge clk);
    end
    exp_cnt++;
    n_cmp++;
    if ({bus.pkt_done, bus.tx_valid, bus.tx_remain, bus.pkt_cnt} !== {1'b1, 1'b0, 8'd0, exp_cnt}) begin
      n_bad++;
      $display("FAIL h_done: got done=%b v=%b rem=%0d cnt=%0d expected 1/0/0/%0d",
               bus.pkt_done, bus.tx_valid, bus.tx_remain, bus.pkt_cnt, exp_cnt);
    end
    n_cmp++;
    if ({bus.err_conflict, bus.err_overlap, bus.err_grant} !== 3'b000) begin
      n_bad++;
      $display("FAIL h_errs: got %b%b%b expected 000",
               bus.err_conflict, bus.err_overlap, bus.err_grant);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.pkt_done !== 1'b0) begin
      n_bad++;
      $display("FAIL h_done_pulse: got %b expected 0", bus.pkt_done);
    end
  endtask

  task automatic test_two_l;
    wait_idle();
    go(1'b0, 2'b10, 8'd0, {8'd8, 8'd0}, 2'b10, 4'd1);
    for (int s = 0; s < 8; s++) begin
      n_cmp++;
      if ({bus.tx_valid, bus.tx_src, bus.tx_remain} !== {1'b1, 4'd2, 8'(7 - s)}) begin
        n_bad++;
        $display("FAIL l1_slot%0d: got v=%b src=%0d rem=%0d expected 1/2/%0d",
                 s, bus.tx_valid, bus.tx_src, bus.tx_remain, 7 - s);
      end
      @(negedge clk);
    end
    exp_cnt++;
    wait_idle();
    go(1'b0, 2'b01, 8'd0, {8'd0, 8'd3}, 2'b10, 4'd0);
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if ({bus.tx_valid, bus.tx_src, bus.tx_last} !== {1'b1, 4'd1, (s == 2)}) begin
        n_bad++;
        $display("FAIL l0_slot%0d: got v=%b src=%0d last=%b expected 1/1/%0d",
                 s, bus.tx_valid, bus.tx_src, bus.tx_last, s == 2);
      end
      @(negedge clk);
    end
    exp_cnt++;
    n_cmp++;
    if ({bus.pkt_done, bus.tx_valid, bus.tx_src, bus.pkt_cnt} !== {1'b1, 1'b0, 4'd1, exp_cnt}) begin
      n_bad++;
      $display("FAIL l_done: got done=%b v=%b src=%0d cnt=%0d expected 1/0/1/%0d",
               bus.pkt_done, bus.tx_valid, bus.tx_src, bus.pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_max_len;
    int slots;
    slots = 0;
    wait_idle();
    go(1'b1, 2'b00, 8'd255, 16'd0, 2'b01, 4'd0);
    n_cmp++;
    if (bus.tx_remain !== 8'd254) begin
      n_bad++;
      $display("FAIL max_first_rem: got %0d expected 254", bus.tx_remain);
    end
    for (int s = 0; s < 260; s++) begin
      if (bus.tx_valid === 1'b1) slots++;
      @(negedge clk);
    end
    exp_cnt++;
    n_cmp++;
    if ({32'(slots), bus.pkt_cnt} !== {32'd255, exp_cnt}) begin
      n_bad++;
      $display("FAIL max_slots: got slots=%0d cnt=%0d expected 255/%0d",
               slots, bus.pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_conflict;
    wait_idle();
    go(1'b1, 2'b01, 8'd5, {8'd0, 8'd5}, 2'b01, 4'd0);
    n_cmp++;
    if ({bus.err_conflict, bus.tx_valid} !== 2'b10) begin
      n_bad++;
      $display("FAIL conflict: got err=%b v=%b expected 1/0",
               bus.err_conflict, bus.tx_valid);
    end
    for (int s = 0; s < 3; s++) begin
      n_cmp++;
      if ({bus.tx_valid, bus.pkt_done, bus.pkt_cnt} !== {2'b00, exp_cnt}) begin
        n_bad++;
        $display("FAIL conflict_idle%0d: got v=%b done=%b cnt=%0d expected 0/0/%0d",
                 s, bus.tx_valid, bus.pkt_done, bus.pkt_cnt, exp_cnt);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_overlap;
    int slots;
    slots = 0;
    wait_idle();
    n_cmp++;
    if (bus.err_overlap !== 1'b0) begin
      n_bad++;
      $display("FAIL overlap_pre: got %b expected 0", bus.err_overlap);
    end
    go(1'b0, 2'b01, 8'd0, {8'd0, 8'd5}, 2'b10, 4'd0);
    bus.bool_go_H = 1'b1;
    bus.pkt_len_H = 8'd7;
    for (int c = 0; c < 5; c++) begin
      if (bus.tx_valid === 1'b1 && bus.tx_src === 4'd1) slots++;
      @(negedge clk);
      bus.bool_go_H = 1'b0;
    end
    exp_cnt++;
    n_cmp++;
    if ({bus.pkt_done, bus.err_overlap, bus.pkt_cnt} !== {2'b11, exp_cnt}) begin
      n_bad++;
      $display("FAIL overlap_send: got done=%b err=%b cnt=%0d expected 1/1/%0d",
               bus.pkt_done, bus.err_overlap, bus.pkt_cnt, exp_cnt);
    end
    bus.bool_go_L = 2'b01;
    bus.pkt_len_L = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.bool_go_L = '0;
      if (bus.tx_valid === 1'b1) slots++;
      n_cmp++;
      if ({bus.pkt_done, bus.pkt_cnt} !== {1'b0, exp_cnt}) begin
        n_bad++;
        $display("FAIL overlap_gap%0d: got done=%b cnt=%0d expected 0/%0d",
                 c, bus.pkt_done, bus.pkt_cnt, exp_cnt);
      end
    end
    n_cmp++;
    if (slots !== 5) begin
      n_bad++;
      $display("FAIL overlap_slots: got %0d expected 5", slots);
    end
    wait_idle();
    go(1'b0, 2'b01, 8'd0, 16'd0, 2'b10, 4'd0);
    exp_cnt++;
    n_cmp++;
    if ({bus.pkt_done, bus.tx_valid, bus.pkt_cnt} !== {2'b10, exp_cnt}) begin
      n_bad++;
      $display("FAIL zero_len: got done=%b v=%b cnt=%0d expected 1/0/%0d",
               bus.pkt_done, bus.tx_valid, bus.pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_grant;
    wait_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    n_cmp++;
    if ({bus.err_grant, bus.err_conflict, bus.err_overlap} !== 3'b000) begin
      n_bad++;
      $display("FAIL grant_pre: got %b%b%b expected 000",
               bus.err_grant, bus.err_conflict, bus.err_overlap);
    end
    go(1'b0, 2'b01, 8'd0, {8'd0, 8'd2}, 2'b01, 4'd0);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({bus.tx_valid, bus.tx_src, bus.err_grant} !== {1'b1, 4'd1, 1'b1}) begin
        n_bad++;
        $display("FAIL grant_slot%0d: got v=%b src=%0d err=%b expected 1/1/1",
                 s, bus.tx_valid, bus.tx_src, bus.err_grant);
      end
      @(negedge clk);
    end
    exp_cnt++;
    n_cmp++;
    if ({bus.pkt_done, bus.pkt_cnt} !== {1'b1, exp_cnt}) begin
      n_bad++;
      $display("FAIL grant_done: got done=%b cnt=%0d expected 1/%0d",
               bus.pkt_done, bus.pkt_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    wait_idle();
    go(1'b0, 2'b10, 8'd0, {8'd8, 8'd0}, 2'b10, 4'd1);
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.tx_valid, bus.tx_src, bus.tx_remain} !== {1'b1, 4'd2, 8'd5}) begin
      n_bad++;
      $display("FAIL mid_slot3: got v=%b src=%0d rem=%0d expected 1/2/5",
               bus.tx_valid, bus.tx_src, bus.tx_remain);
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.tx_valid, bus.tx_src, bus.tx_remain, bus.tx_last, bus.pkt_done,
         bus.pkt_cnt, bus.err_conflict, bus.err_overlap, bus.err_grant} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got v=%b src=%0d rem=%0d cnt=%0d expected all 0",
               bus.tx_valid, bus.tx_src, bus.tx_remain, bus.pkt_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    go(1'b1, 2'b00, 8'd2, 16'd0, 2'b01, 4'd0);
    for (int s = 0; s < 2; s++) begin
      n_cmp++;
      if ({bus.tx_valid, bus.tx_src, bus.tx_remain} !== {1'b1, 4'd0, 8'(1 - s)}) begin
        n_bad++;
        $display("FAIL post_slot%0d: got v=%b src=%0d rem=%0d expected 1/0/%0d",
                 s, bus.tx_valid, bus.tx_src, bus.tx_remain, 1 - s);
      end
      @(negedge clk);
    end
    exp_cnt++;
    n_cmp++;
    if ({bus.pkt_done, bus.pkt_cnt} !== {1'b1, exp_cnt}) begin
      n_bad++;
      $display("FAIL post_done: got done=%b cnt=%0d expected 1/%0d",
               bus.pkt_done, bus.pkt_cnt, exp_cnt);
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_single_h();
    test_two_l();
    test_max_len();
    test_conflict();
    test_overlap();
    test_grant();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
